mdu_seq: RTL and testbench
==========================

# mdu_seq

Multi-cycle multiply/divide sequencer for the five-stage MIPS pipeline. It accepts a MULT/MULTU/DIV/DIVU operation from the execute stage and computes the 64-bit result: the product in one extra cycle, the quotient and remainder by a 32-iteration restoring divider. While it works it holds the pipeline through the hazard unit, and at completion it presents HI/LO with a one-cycle write strobe for the HI/LO register.

## Interface
Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- DIV_ITERS, WIDTH, number of divider iterations (one quotient bit per cycle).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  execute-stage instruction is a mul/div op (level; held while stalled).
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- srca  in  WIDTH  rs operand, already forwarded.
- srcb  in  WIDTH  rt operand, already forwarded.
- flush  in  1  cancel the in-flight operation (execute-stage flush).
- stall  out  1  hold F/D/E stages; combinational.
- busy  out  1  sequencer is in a non-IDLE state; registered.
- done  out  1  one-cycle completion pulse; registered.
- hi  out  WIDTH  product[63:32], or remainder.
- lo  out  WIDTH  product[31:0], or quotient.
- hilo_we  out  1  write both HI and LO; equals done.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 and flush=0: latch srca, srcb and op.
  - MUL ops go to MUL. DIV ops load the divider with the operand magnitudes, clear the iteration counter and go to DIV.
- MUL: form the 64-bit product, signed for MULT and unsigned for MULTU. Register it into hi/lo and go to DONE.
- DIV:
  - Each cycle does one restoring step: shift the remainder left, subtract the divisor, and keep the result if it is non-negative. The new quotient bit is 1 when the result is kept.
  - After DIV_ITERS steps, apply sign fix-up and load hi/lo, then go to DONE.
  - Signed fix-up: the quotient is negated when the operand signs differ. The remainder takes the dividend's sign.
- Divide by zero: lo=all ones, hi=srca. The divider still runs its full length.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0. This falls out of the magnitude/negate path; no special case is needed.
- DONE: done=1 and hilo_we=1 for exactly one cycle, then go to IDLE. hi/lo hold their value until the next completion.
- stall = (start & state==IDLE) | state==MUL | state==DIV, forced to 0 when flush=1. stall is 0 in DONE, so the held instruction advances in the same cycle its result is written.
- Flush in MUL or DIV: return to IDLE next cycle. No done pulse; hi/lo keep their old value.
- Flush together with start in IDLE: the operation is not accepted.
- A start in DONE is ignored; it belongs to the instruction that is leaving.

## Timing
- Reset (async, any state): state=IDLE, counter=0, busy=0, done=0, hilo_we=0, hi=0, lo=0. An operation in progress is discarded.
- Accepted start at edge N:
  - MUL: done is high in cycle N+2; stall is high in cycles N and N+1.
  - DIV: done is high in cycle N+1+DIV_ITERS (cycle N+33 at the default); stall is high for DIV_ITERS+1 cycles.
- A new operation can be accepted in the cycle after DONE (back-to-back).
- Width rules:
  - Product: 2*WIDTH bits, no truncation.
  - Divider: remainder register WIDTH+1 bits for the subtract/compare; quotient WIDTH bits.
  - Counter: clog2(DIV_ITERS)+1 bits.

## Structure
- Package mdu_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state enum: IDLE, MUL, DIV, DONE
  - WIDTH default
- Sub-module div_radix2 holds the iterative divider datapath (remainder/quotient shift registers, subtractor, counter) with load/step/last signals. mdu_seq holds the FSM, multiplier, sign handling and output registers.

## Test plan
- MULT srca=0xFFFFFFFE (-2), srcb=3 -> done at N+2: hi=0xFFFFFFFF, lo=0xFFFFFFFA; stall high for cycles N and N+1 only.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7 / 2 -> done at N+33: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV started, flush at iteration 10 -> IDLE next cycle; no done/hilo_we; hi/lo unchanged; stall drops in the flush cycle.
- rst asserted mid-DIV between clock edges -> all outputs 0 immediately; after release, a MULT 3×4 gives lo=12, hi=0. Back-to-back MULT then DIVU is accepted the cycle after DONE.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide sequencer: operation codes, FSM states, default width.
package mdu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_radix2.sv
// Unsigned restoring divider, one quotient bit per step; ITERS steps after load.
// last flags the final step; quo_next/rem_next carry that step's result combinationally.
module div_radix2 #(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             last,
  output logic [WIDTH-1:0] quo_next,
  output logic [WIDTH-1:0] rem_next
);

  localparam int CW = $clog2(ITERS) + 1;

  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // The dividend is shifted out of the quotient register MSB-first while
  // quotient bits are shifted in at the bottom.
  always_comb begin
    shifted  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    last     = step && (cnt == CW'(ITERS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt   <= '0;
    end else if (step) begin
      rem_q <= {1'b0, rem_next};
      quo_q <= quo_next;
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// MULT/MULTU/DIV/DIVU sequencer: product done 2 cycles after accept, divide DIV_ITERS+1.
// Holds the front of the pipeline via stall while working; flush aborts with no write.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DIV_ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             hilo_we
);

  state_t state, state_nxt;

  logic [WIDTH-1:0]   opa, opb;
  logic [1:0]         op_q;
  logic               q_neg, r_neg;
  logic               accept, div_load, div_step, div_last;
  logic               sgn_div, a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   quo_next, rem_next;
  logic [2*WIDTH-1:0] ext_a, ext_b, product;

  assign accept   = (state == IDLE) && start && !flush;
  assign div_load = accept && is_div_op(op);
  assign div_step = (state == DIV) && !flush;

  assign stall   = !flush && ((start && state == IDLE) || state == MUL || state == DIV);
  assign hilo_we = done;

  always_comb begin
    sgn_div = (op == OP_DIV);
    a_neg   = sgn_div && srca[WIDTH-1];
    b_neg   = sgn_div && srcb[WIDTH-1];
    mag_a   = a_neg ? -srca : srca;
    mag_b   = b_neg ? -srcb : srcb;
  end

  // Full-width product of operands extended to 2*WIDTH; the low 2*WIDTH bits are exact.
  always_comb begin
    ext_a   = (op_q == OP_MULT) ? {{WIDTH{opa[WIDTH-1]}}, opa} : {{WIDTH{1'b0}}, opa};
    ext_b   = (op_q == OP_MULT) ? {{WIDTH{opb[WIDTH-1]}}, opb} : {{WIDTH{1'b0}}, opb};
    product = ext_a * ext_b;
  end

  div_radix2 #(
    .WIDTH (WIDTH),
    .ITERS (DIV_ITERS)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .last     (div_last),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = is_div_op(op) ? DIV : MUL;
      MUL:  state_nxt = flush ? IDLE : DONE;
      DIV:  begin
        if (flush)         state_nxt = IDLE;
        else if (div_last) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      opa   <= '0;
      opb   <= '0;
      op_q  <= OP_MULT;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
      if (accept) begin
        opa   <= srca;
        opb   <= srcb;
        op_q  <= op;
        // A zero divisor leaves the all-ones quotient un-negated.
        q_neg <= (a_neg ^ b_neg) && (srcb != '0);
        r_neg <= a_neg;
      end
      if (state == MUL && !flush) begin
        hi <= product[2*WIDTH-1:WIDTH];
        lo <= product[WIDTH-1:0];
      end
      if (div_last) begin
        hi <= r_neg ? -rem_next : rem_next;
        lo <= q_neg ? -quo_next : quo_next;
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: directed vectors, flush/reset/back-to-back sequences, random ops vs model.
module tb_mdu_seq;
  import mdu_pkg::*;

  localparam int W     = 32;
  localparam int ITERS = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  srca = '0;
  logic [W-1:0]  srcb = '0;
  logic          flush = 1'b0;
  logic          stall, busy, done, hilo_we;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int errors = 0;

  mdu_seq #(.WIDTH(W), .DIV_ITERS(ITERS)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .srca    (srca),
    .srcb    (srcb),
    .flush   (flush),
    .stall   (stall),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .hilo_we (hilo_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string        name;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference results from plain integer arithmetic.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l);
    longint sa, sb, p, r;
    longint unsigned ua, ub, up, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    h = '0;
    l = '0;
    if (o == OP_MULT) begin
      p = sa * sb;
      h = p[63:32];
      l = p[31:0];
    end else if (o == OP_MULTU) begin
      up = ua * ub;
      h = up[63:32];
      l = up[31:0];
    end else if (b == '0) begin
      h = a;
      l = '1;
    end else if (o == OP_DIV) begin
      p = sa / sb;
      r = sa % sb;
      h = r[31:0];
      l = p[31:0];
    end else begin
      up = ua / ub;
      ur = ua % ub;
      h = ur[31:0];
      l = up[31:0];
    end
  endfunction

  // Issue one op in the next cycle, hold start while stalled, check timing and result.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input string name);
    int lat;
    int explat;
    bit stall_ok;
    bit busy_ok;
    explat = o[1] ? ITERS + 1 : 2;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    srca  = a;
    srcb  = b;
    #1;
    chk({name, " stall_at_accept"}, 32'(stall), 32'd1);
    lat = 0;
    stall_ok = 1'b1;
    busy_ok  = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!done) begin
        if (!stall) stall_ok = 1'b0;
        if (!busy)  busy_ok  = 1'b0;
      end
    end while (!done && lat < 100);
    chk({name, " latency"}, 32'(lat), 32'(explat));
    chk({name, " hi"}, hi, eh);
    chk({name, " lo"}, lo, el);
    chk({name, " hilo_we"}, 32'(hilo_we), 32'd1);
    chk({name, " stall_in_done"}, 32'(stall), 32'd0);
    chk({name, " stall_while_busy"}, 32'(stall_ok), 32'd1);
    chk({name, " busy_while_working"}, 32'(busy_ok), 32'd1);
    start = 1'b0;
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb, eh, el;
    bit           saw_done;
    int           lat;

    vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg2x3"};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"};
    vecs[3] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       "divu_100_7"};
    vecs[4] = '{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, "divu_by0"};
    vecs[5] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, "div_ovf"};
    vecs[6] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div_7_m2"};
    vecs[7] = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, "div_m5_by0"};
    vecs[8] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minsq"};
    vecs[9] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, "divu_max_1"};

    // Reset state.
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hilo_we", 32'(hilo_we), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table, issued back-to-back.
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].name);

    // Start held through DONE is not taken as a new op.
    @(negedge clk);
    start = 1'b1; op = OP_MULT; srca = 32'd5; srcb = 32'd6;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!done && lat < 100);
    chk("done_start_lat", 32'(lat), 32'd2);
    @(negedge clk);
    chk("done_start_busy", 32'(busy), 32'd0);
    chk("done_start_done", 32'(done), 32'd0);
    start = 1'b0;
    chk("done_start_lo", lo, 32'd30);

    // Flush together with start in IDLE.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_DIVU; srca = 32'd9; srcb = 32'd2;
    #1;
    chk("idle_flush_stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("idle_flush_busy", 32'(busy), 32'd0);

    // Flush part-way through a divide.
    @(negedge clk);
    start = 1'b1; op = OP_DIV; srca = 32'd1000; srcb = 32'd3;
    repeat (10) @(negedge clk);
    chk("flush_div_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    #1;
    chk("flush_div_stall", 32'(stall), 32'd0);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk("flush_div_busy", 32'(busy), 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || hilo_we) saw_done = 1'b1;
    end
    chk("flush_div_no_done", 32'(saw_done), 32'd0);
    chk("flush_div_hi_kept", hi, 32'd0);
    chk("flush_div_lo_kept", lo, 32'd30);

    // Asynchronous reset mid-divide.
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "pre_rst_div");
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; srca = 32'd100; srcb = 32'd7;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_hilo_we", 32'(hilo_we), 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    run_op(OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, "post_rst_mult");
    run_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "b2b_divu");

    // Random ops against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = '1;
        2: ra = 32'h80000000;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      model(ro, ra, rb, eh, el);
      run_op(ro, ra, rb, eh, el, "rand");
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
